// File: rtl/div.sv
// Sequential unsigned divider using restoring shift-subtract, one quotient bit per
// clock, with a start/done handshake toward the execute stage.
module div #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quot_rd,
    output logic [N-1:0] rem_rd,
    output logic         div_by_zero
);
    localparam int            CW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic [N-1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem_o;
    logic          r_dbz_o;

    logic [N:0]    w_rem_sh;
    logic [N:0]    w_diff;
    logic          w_ge;
    logic [N-1:0]  w_q_nx;
    logic [N-1:0]  w_rem_nx;
    logic          w_last;

    // One restoring step. The shifted remainder keeps its carry-out bit, so the
    // trial subtract is N+1 bits and its sign bit doubles as the compare result.
    always_comb begin
        w_rem_sh = {r_rem, r_q[N-1]};
        w_diff   = w_rem_sh - {1'b0, r_d};
        w_ge     = ~w_diff[N];
        w_q_nx   = {r_q[N-2:0], w_ge};
        if (w_ge) begin
            w_rem_nx = w_diff[N-1:0];
        end else begin
            w_rem_nx = w_rem_sh[N-1:0];
        end
        w_last   = (r_cnt == LAST_CNT);
    end

    // Next-state logic; a zero divisor spends one CALC cycle and then finishes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_dbz || w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Operand capture, iteration and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem_o <= '0;
            r_dbz_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q   <= rs1;
                        r_d   <= rs2;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_dbz <= (rs2 == '0);
                    end
                end
                S_CALC: begin
                    if (r_dbz) begin
                        // r_q still holds the untouched dividend here.
                        r_quot  <= '1;
                        r_rem_o <= r_q;
                        r_dbz_o <= 1'b1;
                    end else begin
                        r_q   <= w_q_nx;
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quot  <= w_q_nx;
                            r_rem_o <= w_rem_nx;
                            r_dbz_o <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quot_rd     = r_quot;
    assign rem_rd      = r_rem_o;
    assign div_by_zero = r_dbz_o;

endmodule
